// File: rtl/citi_sample_sequencer.sv
// rtl/citi_sample_sequencer.sv - paced sample streamer and result collector for the citi IIR summer
module citi_sample_sequencer #(
    parameter int N      = 8,
    parameter int W      = 16,
    parameter int PERIOD = 30,
    parameter int PASSES = 3,
    parameter int FDEPTH = 4
) (
    input  logic                 clk30x_i,
    input  logic                 rst_n_i,
    input  logic                 load_we_i,
    input  logic [$clog2(N)-1:0] load_addr_i,
    input  logic [W-1:0]         load_data_i,
    input  logic                 start_i,
    output logic [W-1:0]         xin_o,
    output logic                 donext_o,
    input  logic [W-1:0]         yout_i,
    output logic                 res_valid_o,
    input  logic                 res_ready_i,
    output logic [31:0]          res_data_o,
    output logic [$clog2(N)-1:0] res_idx_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 ovf_o
);

    localparam int AW    = $clog2(N);
    localparam int TOTAL = PASSES * N;
    localparam int KW    = $clog2(TOTAL) + 1;
    localparam int TW    = $clog2(PERIOD);
    localparam int FW    = $clog2(FDEPTH);

    // WAIT is entered with PERIOD-1 after start (the start edge itself counts as
    // one clock) and PERIOD-2 after a strobe (the STROBE cycle counts as one).
    localparam logic [TW-1:0] T_FIRST = TW'(PERIOD - 1);
    localparam logic [TW-1:0] T_NEXT  = TW'(PERIOD - 2);
    localparam logic [KW-1:0] K_LAST  = KW'(TOTAL - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_STROBE,
        S_TAIL,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t        state_q;
    logic [TW-1:0] timer_q;
    logic [KW-1:0] k_q;
    logic [W-1:0]  xin_q;
    logic          donext_q;
    logic          busy_q;
    logic          done_q;

    logic [W-1:0]  ram_q [N];

    logic [W-1:0]  fdata_q [FDEPTH];
    logic [AW-1:0] fidx_q  [FDEPTH];
    logic [FW-1:0] wr_q;
    logic [FW-1:0] rd_q;
    logic [FW:0]   cnt_q;
    logic          ovf_q;

    logic          start_acc;
    logic          cap_push;
    logic [AW-1:0] cap_idx;
    logic          fifo_full;
    logic          fifo_pop;
    logic          push_ok;

    assign start_acc = (state_q == S_IDLE) && start_i;

    // Sample RAM: host writes only while idle; contents survive reset.
    always_ff @(posedge clk30x_i) begin
        if (load_we_i && (state_q == S_IDLE)) begin
            ram_q[load_addr_i] <= load_data_i;
        end
    end

    // Capture happens on the edge that issues strobe k (k>=1) or enters FLUSH,
    // so yout still reflects the previous sample when it is taken.
    always_comb begin
        cap_push = 1'b0;
        cap_idx  = k_q[AW-1:0];
        if (timer_q == '0) begin
            if ((state_q == S_WAIT) && (k_q != '0)) begin
                cap_push = 1'b1;
                cap_idx  = AW'(k_q - KW'(1));
            end else if (state_q == S_TAIL) begin
                cap_push = 1'b1;
            end
        end
    end

    // Run sequencer: pacing timer, strobe counter and registered strobe outputs.
    always_ff @(posedge clk30x_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= S_IDLE;
            timer_q  <= '0;
            k_q      <= '0;
            xin_q    <= '0;
            donext_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            donext_q <= 1'b0;
            done_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        state_q <= S_WAIT;
                        timer_q <= T_FIRST;
                        k_q     <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (timer_q == '0) begin
                        state_q  <= S_STROBE;
                        donext_q <= 1'b1;
                        xin_q    <= ram_q[k_q[AW-1:0]];
                    end else begin
                        timer_q <= timer_q - TW'(1);
                    end
                end
                S_STROBE: begin
                    timer_q <= T_NEXT;
                    if (k_q == K_LAST) begin
                        state_q <= S_TAIL;
                    end else begin
                        k_q     <= k_q + KW'(1);
                        state_q <= S_WAIT;
                    end
                end
                S_TAIL: begin
                    if (timer_q == '0) begin
                        state_q <= S_FLUSH;
                    end else begin
                        timer_q <= timer_q - TW'(1);
                    end
                end
                S_FLUSH: begin
                    state_q <= S_DONE;
                    done_q  <= 1'b1;
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    k_q     <= '0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign fifo_full = (cnt_q == (FW + 1)'(FDEPTH));
    assign fifo_pop  = res_valid_o && res_ready_i;
    assign push_ok   = cap_push && (!fifo_full || fifo_pop);

    // Result FIFO storage; no reset needed since cnt_q gates visibility.
    always_ff @(posedge clk30x_i) begin
        if (push_ok) begin
            fdata_q[wr_q] <= yout_i;
            fidx_q[wr_q]  <= cap_idx;
        end
    end

    // Result FIFO pointers, occupancy and sticky overflow flag.
    always_ff @(posedge clk30x_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_q <= wr_q + FW'(1);
            end
            if (fifo_pop) begin
                rd_q <= rd_q + FW'(1);
            end
            case ({push_ok, fifo_pop})
                2'b10:   cnt_q <= cnt_q + (FW + 1)'(1);
                2'b01:   cnt_q <= cnt_q - (FW + 1)'(1);
                default: cnt_q <= cnt_q;
            endcase
            if (start_acc) begin
                ovf_q <= 1'b0;
            end else if (cap_push && !push_ok) begin
                ovf_q <= 1'b1;
            end
        end
    end

    assign res_valid_o = (cnt_q != '0);
    assign res_data_o  = res_valid_o ? {{(32 - W){fdata_q[rd_q][W-1]}}, fdata_q[rd_q]} : '0;
    assign res_idx_o   = res_valid_o ? fidx_q[rd_q] : '0;
    assign xin_o       = xin_q;
    assign donext_o    = donext_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign ovf_o       = ovf_q;

endmodule
